dll_rx_demux: RTL and testbench

- Receive-side counterpart of the DLL TX arbiter.
- Takes 32B PIPE receive beats from the PHY and parses the framing tokens.
- Routes TLP beats to the TLP receive path (toward the LCRC check / RX buffer) and extracts DLLPs to the DLLP receive path (Ack/Nak, InitFC, UpdateFC processing).
- Gates TLP delivery on DL_up. Flags framing errors to the DLCMSM.

---
 rtl/dll_pkg.sv | 35 +++
 rtl/dll_rx_token_decode.sv | 33 +++
 rtl/dll_rx_demux.sv | 198 +++++++++++++++++++
 tb/tb_dll_rx_demux.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dll_pkg.sv
// ---------------------------------------------------------------------------
// dll_pkg
// Shared definitions for the DLL receive path: framing token encodings,
// DLLP width, the receive FSM state type, the token class type and a helper
// that extracts the 11-bit STP length field.
// ---------------------------------------------------------------------------
package dll_pkg;

    localparam logic [3:0] STP_NIBBLE = 4'hF;
    localparam logic [7:0] SDP_BYTE0  = 8'hF0;
    localparam logic [7:0] SDP_BYTE1  = 8'hAC;
    localparam logic [7:0] IDL_BYTE   = 8'h00;

    // 4B DLLP body plus 2B CRC
    localparam int DLLP_WIDTH = 48;

    typedef enum logic {
        RX_IDLE     = 1'b0,
        RX_TLP_BODY = 1'b1
    } rx_state_t;

    typedef enum logic [1:0] {
        TOK_IDL = 2'd0,
        TOK_SDP = 2'd1,
        TOK_STP = 2'd2,
        TOK_BAD = 2'd3
    } rx_tok_t;

    // STP length is {byte1[6:0], byte0[7:4]}; byte1[7] is dropped by the cast.
    function automatic logic [10:0] stp_len(input logic [7:0] byte0,
                                            input logic [7:0] byte1);
        return 11'({byte1, byte0} >> 4);
    endfunction

endpackage

// File: rtl/dll_rx_token_decode.sv
// ---------------------------------------------------------------------------
// dll_rx_token_decode
// Combinational classification of the first two bytes of a PIPE beat.
//   byte0_i  : beat byte 0
//   byte1_i  : beat byte 1
//   tok_o    : token class (IDL, SDP, STP, BAD)
//   len_o    : STP length field; meaningful only when tok_o == TOK_STP
// ---------------------------------------------------------------------------
module dll_rx_token_decode
    import dll_pkg::*;
(
    input  logic [7:0]  byte0_i,
    input  logic [7:0]  byte1_i,
    output rx_tok_t     tok_o,
    output logic [10:0] len_o
);

    always_comb begin
        tok_o = TOK_BAD;
        // SDP first: 8'hF0 has a zero low nibble, so it can never look like STP,
        // but checking it first keeps the priority obvious.
        if (byte0_i == SDP_BYTE0 && byte1_i == SDP_BYTE1) begin
            tok_o = TOK_SDP;
        end else if (byte0_i[3:0] == STP_NIBBLE) begin
            tok_o = TOK_STP;
        end else if (byte0_i == IDL_BYTE) begin
            tok_o = TOK_IDL;
        end
    end

    assign len_o = stp_len(byte0_i, byte1_i);

endmodule

// File: rtl/dll_rx_demux.sv
// ---------------------------------------------------------------------------
// dll_rx_demux
// Receive-side framing parser. Splits 32B PIPE beats into a TLP stream and a
// DLLP stream and flags framing errors.
//
// Handshake: valid-only. A beat is consumed on every clock where its valid is
// high; there is no ready on either side, so the consumer must accept every
// beat. Every output is registered one cycle after the input beat.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   DL_up             : TLPs are forwarded only while high (sampled at sop)
//   pipe_valid_i      : PIPE beat valid
//   pipe_data_i       : PIPE beat, byte 0 in [7:0]
//   tlp_32B_buffer_o  : TLP beat (STP DW and LCRC DW included)
//   tlp_valid_o       : TLP beat valid
//   tlp_sop_o         : first TLP beat
//   tlp_eop_o         : last TLP beat
//   tlp_len_dw_o      : TLP length in DW, valid with tlp_sop_o
//   dllp_o            : DLLP bytes 2..7 of an SDP beat
//   dllp_valid_o      : single-cycle DLLP strobe
//   framing_err_o     : single-cycle framing error strobe
//   rx_state_o        : current FSM state, for observation
// ---------------------------------------------------------------------------
module dll_rx_demux
    import dll_pkg::*;
#(
    parameter int PIPE_DATA_WIDTH = 256,
    parameter int MAX_TLP_LEN_DW  = 74,
    parameter int MIN_TLP_LEN_DW  = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       DL_up,
    input  logic                       pipe_valid_i,
    input  logic [PIPE_DATA_WIDTH-1:0] pipe_data_i,
    output logic [PIPE_DATA_WIDTH-1:0] tlp_32B_buffer_o,
    output logic                       tlp_valid_o,
    output logic                       tlp_sop_o,
    output logic                       tlp_eop_o,
    output logic [10:0]                tlp_len_dw_o,
    output logic [DLLP_WIDTH-1:0]      dllp_o,
    output logic                       dllp_valid_o,
    output logic                       framing_err_o,
    output rx_state_t                  rx_state_o
);

    localparam int CNT_W = $clog2(MAX_TLP_LEN_DW / 8 + 1);

    // ---------------- token decode ----------------
    rx_tok_t     tok;
    logic [10:0] tok_len;

    dll_rx_token_decode u_decode (
        .byte0_i (pipe_data_i[7:0]),
        .byte1_i (pipe_data_i[15:8]),
        .tok_o   (tok),
        .len_o   (tok_len)
    );

    logic        len_ok;
    logic [10:0] tok_beats;

    assign len_ok    = (tok_len >= 11'(MIN_TLP_LEN_DW)) &&
                       (tok_len <= 11'(MAX_TLP_LEN_DW));
    // 8 DW per 32B beat, rounded up. len is at most 11 bits and only used
    // after len_ok, so the +7 cannot overflow for any legal length.
    assign tok_beats = (tok_len + 11'd7) >> 3;

    // ---------------- state ----------------
    rx_state_t                  state_q, state_d;
    logic [CNT_W-1:0]           beats_left_q, beats_left_d;
    logic                       pass_q, pass_d;
    logic [PIPE_DATA_WIDTH-1:0] buf_q, buf_d;
    logic                       tlp_valid_q, tlp_valid_d;
    logic                       sop_q, sop_d;
    logic                       eop_q, eop_d;
    logic [10:0]                len_q, len_d;
    logic [DLLP_WIDTH-1:0]      dllp_q, dllp_d;
    logic                       dllp_valid_q, dllp_valid_d;
    logic                       err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RX_IDLE;
            beats_left_q <= '0;
            pass_q       <= 1'b0;
            buf_q        <= '0;
            tlp_valid_q  <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            len_q        <= '0;
            dllp_q       <= '0;
            dllp_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            beats_left_q <= beats_left_d;
            pass_q       <= pass_d;
            buf_q        <= buf_d;
            tlp_valid_q  <= tlp_valid_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            len_q        <= len_d;
            dllp_q       <= dllp_d;
            dllp_valid_q <= dllp_valid_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        // Strobes default low; data registers hold their last value.
        state_d      = state_q;
        beats_left_d = beats_left_q;
        pass_d       = pass_q;
        buf_d        = buf_q;
        tlp_valid_d  = 1'b0;
        sop_d        = 1'b0;
        eop_d        = 1'b0;
        len_d        = len_q;
        dllp_d       = dllp_q;
        dllp_valid_d = 1'b0;
        err_d        = 1'b0;

        unique case (state_q)
            RX_IDLE: begin
                if (pipe_valid_i) begin
                    unique case (tok)
                        TOK_SDP: begin
                            // Not gated by DL_up: InitFC must flow before link up.
                            dllp_d       = pipe_data_i[63:16];
                            dllp_valid_d = 1'b1;
                        end
                        TOK_STP: begin
                            if (len_ok) begin
                                // DL_up is latched here so a mid-packet drop
                                // never truncates a packet already passing.
                                pass_d = DL_up;
                                if (DL_up) begin
                                    tlp_valid_d = 1'b1;
                                    sop_d       = 1'b1;
                                    len_d       = tok_len;
                                    buf_d       = pipe_data_i;
                                end
                                if (tok_beats == 11'd1) begin
                                    eop_d = DL_up;
                                end else begin
                                    beats_left_d = CNT_W'(tok_beats - 11'd1);
                                    state_d      = RX_TLP_BODY;
                                end
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        TOK_IDL: begin
                        end
                        default: begin
                            err_d = 1'b1;
                        end
                    endcase
                end
            end

            RX_TLP_BODY: begin
                // Body beats are never token-decoded; a blocked packet is
                // still consumed so the framing stays aligned.
                if (pipe_valid_i) begin
                    if (pass_q) begin
                        tlp_valid_d = 1'b1;
                        buf_d       = pipe_data_i;
                    end
                    if (beats_left_q == CNT_W'(1)) begin
                        eop_d        = pass_q;
                        beats_left_d = '0;
                        state_d      = RX_IDLE;
                    end else begin
                        beats_left_d = beats_left_q - CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    assign tlp_32B_buffer_o = buf_q;
    assign tlp_valid_o      = tlp_valid_q;
    assign tlp_sop_o        = sop_q;
    assign tlp_eop_o        = eop_q;
    assign tlp_len_dw_o     = len_q;
    assign dllp_o           = dllp_q;
    assign dllp_valid_o     = dllp_valid_q;
    assign framing_err_o    = err_q;
    assign rx_state_o       = state_q;

endmodule

// File: tb/tb_dll_rx_demux.sv
module tb_dll_rx_demux;
  import dll_pkg::*;

  localparam int W = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          dl_up = 1'b0;
  logic          pipe_valid = 1'b0;
  logic [W-1:0]  pipe_data = '0;
  logic [W-1:0]  tlp_buf;
  logic          tlp_valid, tlp_sop, tlp_eop;
  logic [10:0]   tlp_len;
  logic [47:0]   dllp;
  logic          dllp_valid, framing_err;
  rx_state_t     rx_state;

  dll_rx_demux dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .DL_up            (dl_up),
    .pipe_valid_i     (pipe_valid),
    .pipe_data_i      (pipe_data),
    .tlp_32B_buffer_o (tlp_buf),
    .tlp_valid_o      (tlp_valid),
    .tlp_sop_o        (tlp_sop),
    .tlp_eop_o        (tlp_eop),
    .tlp_len_dw_o     (tlp_len),
    .dllp_o           (dllp),
    .dllp_valid_o     (dllp_valid),
    .framing_err_o    (framing_err),
    .rx_state_o       (rx_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Packet-level view: a packet owns ceil(len*4/32) beats; remaining beats
  // are swallowed without decode and forwarded only if the link was up at sop.
  int           m_left = 0;
  bit           m_pass = 1'b0;
  logic [W-1:0] e_buf = '0;
  logic         e_tlp_valid = 0, e_sop = 0, e_eop = 0, e_dllp_valid = 0, e_err = 0;
  logic [10:0]  e_len = '0;
  logic [47:0]  e_dllp = '0;

  task automatic model_reset();
    m_left = 0; m_pass = 0;
    e_buf = '0; e_len = '0; e_dllp = '0;
    e_tlp_valid = 0; e_sop = 0; e_eop = 0; e_dllp_valid = 0; e_err = 0;
  endtask

  task automatic model_step();
    int len, nbeats;
    logic [7:0] b0, b1;
    e_tlp_valid = 0; e_sop = 0; e_eop = 0; e_dllp_valid = 0; e_err = 0;
    if (!rst_n) begin
      model_reset();
    end else if (pipe_valid) begin
      b0 = pipe_data[7:0];
      b1 = pipe_data[15:8];
      if (m_left > 0) begin
        if (m_pass) begin
          e_tlp_valid = 1; e_buf = pipe_data; e_eop = (m_left == 1);
        end
        m_left = m_left - 1;
      end else if (b0 == 8'hF0 && b1 == 8'hAC) begin
        e_dllp = pipe_data[63:16]; e_dllp_valid = 1;
      end else if (b0[3:0] == 4'hF) begin
        len = int'(b1[6:0]) * 16 + int'(b0[7:4]);
        if (len >= 5 && len <= 74) begin
          nbeats = (len * 4 + 31) / 32;
          m_pass = dl_up;
          m_left = nbeats - 1;
          if (dl_up) begin
            e_tlp_valid = 1; e_sop = 1; e_len = 11'(len); e_buf = pipe_data;
            e_eop = (nbeats == 1);
          end
        end else begin
          e_err = 1;
        end
      end else if (b0 != 8'h00) begin
        e_err = 1;
      end
    end
  endtask

  always @(negedge rst_n) model_reset();

  // ---------------- compare process + pulse monitor ----------------
  int n_tlp = 0, n_sop = 0, n_eop = 0, n_dllp = 0, n_err = 0;
  logic [10:0] last_len = '0;
  logic [47:0] last_dllp = '0;

  always @(posedge clk) begin
    model_step();
    #1;
    cmp("tlp_valid", W'(tlp_valid), W'(e_tlp_valid));
    cmp("tlp_sop", W'(tlp_sop), W'(e_sop));
    cmp("tlp_eop", W'(tlp_eop), W'(e_eop));
    cmp("tlp_len", W'(tlp_len), W'(e_len));
    cmp("tlp_buf", tlp_buf, e_buf);
    cmp("dllp", W'(dllp), W'(e_dllp));
    cmp("dllp_valid", W'(dllp_valid), W'(e_dllp_valid));
    cmp("framing_err", W'(framing_err), W'(e_err));
    cmp("rx_state", W'(rx_state), W'(m_left > 0));
    if (tlp_valid) n_tlp++;
    if (tlp_sop) begin n_sop++; last_len = tlp_len; end
    if (tlp_eop) n_eop++;
    if (dllp_valid) begin n_dllp++; last_dllp = dllp; end
    if (framing_err) n_err++;
  end

  // ---------------- driver tasks ----------------
  int b_tlp, b_sop, b_eop, b_dllp, b_err;

  task automatic beat(input logic v, input logic [W-1:0] d);
    @(negedge clk);
    pipe_valid = v;
    pipe_data  = d;
  endtask

  function automatic logic [W-1:0] mk(input logic [7:0] b0, input logic [7:0] b1,
                                      input logic [7:0] tag);
    logic [W-1:0] d;
    d = {32{tag}};
    d[7:0]  = b0;
    d[15:8] = b1;
    return d;
  endfunction

  task automatic start_test();
    b_tlp = n_tlp; b_sop = n_sop; b_eop = n_eop; b_dllp = n_dllp; b_err = n_err;
  endtask

  // Idle one cycle so the last registered output has been counted.
  task automatic end_test(input string name, input int t, input int s, input int e,
                          input int dl, input int er);
    beat(1'b0, '0);
    cmp({name, "_tlp_cnt"}, W'(n_tlp - b_tlp), W'(t));
    cmp({name, "_sop_cnt"}, W'(n_sop - b_sop), W'(s));
    cmp({name, "_eop_cnt"}, W'(n_eop - b_eop), W'(e));
    cmp({name, "_dllp_cnt"}, W'(n_dllp - b_dllp), W'(dl));
    cmp({name, "_err_cnt"}, W'(n_err - b_err), W'(er));
  endtask

  logic [W-1:0] sdp_beat;

  initial begin
    sdp_beat = '0;
    sdp_beat[63:0] = 64'h5544_3322_1100_ACF0;

    // reset state
    #1;
    cmp("rst_tlp_valid", W'(tlp_valid), '0);
    cmp("rst_dllp", W'(dllp), '0);
    cmp("rst_state", W'(rx_state), '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: DLLP while link down
    dl_up = 0;
    start_test();
    beat(1'b1, sdp_beat);
    end_test("t1", 0, 0, 0, 1, 0);
    cmp("t1_dllp_lit", W'(last_dllp), W'(48'h554433221100));

    // T2: len 20 -> 3 beats, gap cycle, DL_up dropped mid-packet
    dl_up = 1;
    start_test();
    beat(1'b1, mk(8'h4F, 8'h01, 8'hA1));
    beat(1'b0, mk(8'h00, 8'h00, 8'hEE));
    dl_up = 0;
    beat(1'b1, mk(8'hA2, 8'hA2, 8'hA2));
    beat(1'b1, mk(8'hA3, 8'hA3, 8'hA3));
    end_test("t2", 3, 1, 1, 0, 0);
    cmp("t2_len_lit", W'(last_len), W'(11'd20));

    // T3: minimum length single beat, then SDP
    dl_up = 1;
    start_test();
    beat(1'b1, mk(8'h5F, 8'h00, 8'hB1));
    beat(1'b1, sdp_beat);
    end_test("t3", 1, 1, 1, 1, 0);
    cmp("t3_len_lit", W'(last_len), W'(11'd5));

    // T4: link down TLP consumed; body bytes look like bad tokens but are not decoded
    dl_up = 0;
    start_test();
    beat(1'b1, mk(8'h4F, 8'h01, 8'h3C));
    beat(1'b1, mk(8'h3C, 8'h3C, 8'h3C));
    beat(1'b1, mk(8'h3C, 8'h3C, 8'h3C));
    beat(1'b1, sdp_beat);
    end_test("t4", 0, 0, 0, 1, 0);

    // T5: bad token, too short, too long
    dl_up = 1;
    start_test();
    beat(1'b1, mk(8'h3C, 8'h00, 8'h11));
    beat(1'b1, mk(8'h4F, 8'h00, 8'h22));
    beat(1'b1, mk(8'hBF, 8'h04, 8'h33));
    beat(1'b1, mk(8'h00, 8'h00, 8'h44));
    end_test("t5", 0, 0, 0, 0, 3);
    cmp("t5_state", W'(rx_state), '0);

    // T6: reset mid-packet
    dl_up = 1;
    start_test();
    beat(1'b1, mk(8'h4F, 8'h01, 8'hC1));
    beat(1'b1, mk(8'hC2, 8'hC2, 8'hC2));
    @(negedge clk);
    rst_n = 0;
    pipe_valid = 0;
    #1;
    cmp("t6_rst_valid", W'(tlp_valid), '0);
    cmp("t6_rst_buf", tlp_buf, '0);
    cmp("t6_rst_len", W'(tlp_len), '0);
    cmp("t6_rst_state", W'(rx_state), '0);
    @(negedge clk);
    rst_n = 1;
    beat(1'b1, sdp_beat);
    beat(1'b1, mk(8'h3C, 8'hC3, 8'hC3));
    end_test("t6", 2, 1, 0, 1, 1);

    // T7: maximum length, 10 beats
    dl_up = 1;
    start_test();
    beat(1'b1, mk(8'hAF, 8'h04, 8'hD0));
    for (int i = 1; i < 10; i++) beat(1'b1, mk(8'(i), 8'(i), 8'(8'hD0 + i)));
    end_test("t7", 10, 1, 1, 0, 0);
    cmp("t7_len_lit", W'(last_len), W'(11'd74));
    cmp("t7_state", W'(rx_state), '0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
